mix_columns_seq: RTL and testbench

- Sequential MixColumns / InvMixColumns stage that consumes the 128-bit state produced by shift_row (encrypt path) and produces the state for AddRoundKey.
- Processes one 32-bit column per clock through a single shared column multiplier, trading 4 cycles of latency for area.
- Uses a valid/ready handshake on both sides so the round controller can stall it.
- A mode bit selects forward or inverse transform, so one instance serves both datapaths.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/mix_single_column.sv | 33 +++
 rtl/mix_columns_seq.sv | 77 +++++++
 tb/tb_mix_columns_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the MixColumns datapath modules.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         NUM_COLS = 4;

    // Byte and column use ascending bit order: bit 0 is the MSB.
    typedef logic [0:7]  byte_t;
    typedef logic [0:31] column_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic byte_t xtime(input byte_t b);
        byte_t sh;
        sh = {b[1:7], 1'b0};
        return sh ^ (b[0] ? AES_POLY : 8'h00);
    endfunction

    // Constant multiply. c is one of 1, 2, 3, 9, b, d, e.
    function automatic byte_t gf_mul(input byte_t b, input logic [3:0] c);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b  : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^
               (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns on one 32-bit column.
// Ports: col_in (row 0 in bits 0:7), inverse, col_out.
module mix_single_column (
    input  logic [0:31] col_in,
    input  logic        inverse,
    output logic [0:31] col_out
);
    import aes_pkg::*;

    byte_t a0, a1, a2, a3;
    logic [3:0] k0, k1, k2, k3;

    assign a0 = col_in[0:7];
    assign a1 = col_in[8:15];
    assign a2 = col_in[16:23];
    assign a3 = col_in[24:31];

    // First row of the circulant matrix; later rows rotate it right.
    assign k0 = inverse ? 4'hE : 4'h2;
    assign k1 = inverse ? 4'hB : 4'h3;
    assign k2 = inverse ? 4'hD : 4'h1;
    assign k3 = inverse ? 4'h9 : 4'h1;

    assign col_out[0:7]   = gf_mul(a0, k0) ^ gf_mul(a1, k1)
                          ^ gf_mul(a2, k2) ^ gf_mul(a3, k3);
    assign col_out[8:15]  = gf_mul(a0, k3) ^ gf_mul(a1, k0)
                          ^ gf_mul(a2, k1) ^ gf_mul(a3, k2);
    assign col_out[16:23] = gf_mul(a0, k2) ^ gf_mul(a1, k3)
                          ^ gf_mul(a2, k0) ^ gf_mul(a3, k1);
    assign col_out[24:31] = gf_mul(a0, k1) ^ gf_mul(a1, k2)
                          ^ gf_mul(a2, k3) ^ gf_mul(a3, k0);

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential (Inv)MixColumns: one column per clock, valid/ready both sides.
// Ports: clk, rst, in_valid/in_ready/inverse/inp_matrix, out_valid/out_ready/mixed_matrix.
module mix_columns_seq #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [0:127] inp_matrix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] mixed_matrix
);
    import aes_pkg::*;

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    state_t       state;
    logic [1:0]   col_cnt;
    logic         mode;
    logic [0:127] work;
    column_t      col_in;
    column_t      col_out;

    assign col_in = work[{col_cnt, 5'b0} +: 32];

    mix_single_column u_col (
        .col_in  (col_in),
        .inverse (mode),
        .col_out (col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            col_cnt      <= '0;
            mode         <= 1'b0;
            work         <= '0;
            mixed_matrix <= '0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= inp_matrix;
                        mode     <= inverse;
                        col_cnt  <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    mixed_matrix[{col_cnt, 5'b0} +: 32] <= col_out;
                    if (col_cnt == LAST_COL) begin
                        col_cnt   <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        col_cnt <= col_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq.
// Directed steps plus random blocks against a GF(2^8) reference model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         inverse;
    logic [0:127] inp_matrix;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] mixed_matrix;

    int total = 0;
    int fails = 0;

    mix_columns_seq #(.NUM_COLS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inverse      (inverse),
        .inp_matrix   (inp_matrix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mixed_matrix (mixed_matrix)
    );

    always #5 clk = ~clk;

    // Plain shift-and-add field multiply with 0x11B reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] acc;
        logic [127:0] r;
        if (inv) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = d[127 - 8*(4*c+j) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], a[j]);
                r[127 - 8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one block, wait for the result, check latency and value.
    // perturb: scramble inputs every cycle while the block is in flight.
    // hold: cycles to keep out_ready low in DONE.
    task automatic run_block(input string tag, input logic [127:0] d, input logic inv,
                             input logic [127:0] exp, input bit perturb, input int hold);
        int k;
        logic [127:0] held;
        k = 0;
        while (!in_ready && k < 20) begin step(); k++; end
        chk({tag, "_ready"}, 128'(in_ready), 128'(1));
        in_valid   = 1'b1;
        inp_matrix = d;
        inverse    = inv;
        out_ready  = 1'b0;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            if (perturb) begin
                inp_matrix = rnd128();
                inverse    = 1'($urandom);
            end
            step();
            k++;
        end
        chk({tag, "_lat"}, 128'(k), 128'(4));
        chk({tag, "_val"}, mixed_matrix, exp);
        held = mixed_matrix;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_v"}, 128'({out_valid, in_ready}), 128'(2'b10));
            chk({tag, "_hold_d"}, mixed_matrix, held);
        end
        out_ready = 1'b1;
        step();
        chk({tag, "_rel"}, 128'({out_valid, in_ready}), 128'(2'b01));
        out_ready = 1'b0;
    endtask

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    initial begin
        logic [127:0] d;
        logic         inv;
        logic [127:0] q_in  [3];
        logic         q_inv [3];
        int           sent;
        int           got;
        int           last_t;
        int           cyc;

        rst        = 1'b1;
        in_valid   = 1'b0;
        inverse    = 1'b0;
        inp_matrix = '0;
        out_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_flags", 128'({in_ready, out_valid}), 128'(2'b10));
        chk("reset_data", mixed_matrix, 128'h0);

        run_block("fips_fwd", V_PLAIN, 1'b0, V_MIXED, 1'b0, 0);
        run_block("fips_inv", V_MIXED, 1'b1, V_PLAIN, 1'b0, 0);
        run_block("v2_fwd", V2_IN, 1'b0, V2_OUT, 1'b0, 0);
        run_block("v2_inv", V2_OUT, 1'b1, V2_IN, 1'b0, 0);
        run_block("backpr", V_PLAIN, 1'b0, V_MIXED, 1'b0, 10);

        d = rnd128();
        run_block("perturb", d, 1'b1, ref_mix(d, 1'b1), 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            d   = rnd128();
            inv = 1'($urandom);
            run_block("rand", d, inv, ref_mix(d, inv), 1'b0, i % 3);
        end

        // Abort after two columns have been written.
        in_valid   = 1'b1;
        inp_matrix = V_PLAIN;
        inverse    = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_flags", 128'({in_ready, out_valid}), 128'(2'b10));
        chk("abort_data", mixed_matrix, 128'h0);
        run_block("after_abort", V2_IN, 1'b0, V2_OUT, 1'b0, 0);

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 3; i++) begin
            q_in[i]  = rnd128();
            q_inv[i] = 1'($urandom);
        end
        sent       = 0;
        got        = 0;
        last_t     = 0;
        cyc        = 0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        inp_matrix = q_in[0];
        inverse    = q_inv[0];
        while (got < 3 && cyc < 60) begin
            automatic bit acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    inp_matrix = q_in[sent];
                    inverse    = q_inv[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("b2b_val", mixed_matrix, ref_mix(q_in[got], q_inv[got]));
                if (got > 0) chk("b2b_gap", 128'(cyc - last_t), 128'(6));
                last_t = cyc;
                got++;
            end
        end
        chk("b2b_count", 128'(got), 128'(3));
        repeat (8) step();
        chk("b2b_nodup", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
